// File: rtl/micro_pkg.sv
// Shared types and default build constants for the data-memory responder.
package micro_pkg;

  // Responder phases: accept a request, count wait states, present the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_DEPTH_WORDS = 64;
  localparam int unsigned DEF_WAIT_STATES = 2;

endpackage

// File: rtl/dmem_resp_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
module dmem_resp_array
  import micro_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write on request, otherwise capture the addressed word when a read is asked for.
  // NOTE: no reset here on purpose; a reset on a memory array prevents RAM inference
  // and the contents are allowed to be undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Valid/ready data-memory responder with a fixed number of wait states.
// One request in flight; the storage access happens on the edge entering RESP.
module dmem_resp
  import micro_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_write_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_wdata_q;

  logic        accept;
  logic        enter_resp;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic        arr_we;
  logic        arr_re;
  logic [31:0] arr_rdata;

  // Misaligned, or any bit above the word index is set.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != 32'd0);
  endfunction

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states RESP is entered on the acceptance edge itself, before the
  // capture registers hold the request, so the live request is used in that case.
  assign cur_write = accept ? req_write : cap_write_q;
  assign cur_addr  = accept ? req_addr  : cap_addr_q;
  assign cur_wdata = accept ? req_wdata : cap_wdata_q;
  assign cur_err   = addr_err(cur_addr);

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign arr_we     = enter_resp &&  cur_write && !cur_err;
  assign arr_re     = enter_resp && !cur_write && !cur_err;

  // Next-state, wait counter and handshake outputs.
  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and request capture; reset discards anything pending.
  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cap_write_q <= 1'b0;
      cap_addr_q  <= 32'd0;
      cap_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_write_q <= req_write;
        cap_addr_q  <= req_addr;
        cap_wdata_q <= req_wdata;
      end
    end
  end

  dmem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (cur_addr[IDX_W+1:2]),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );

  // Response payload is gated by state, so it reads as zero outside RESP and for
  // stores or errors, and holds still for as long as RESP lasts.
  assign rsp_err   = rsp_valid && addr_err(cap_addr_q);
  assign rsp_rdata = (rsp_valid && !cap_write_q && !rsp_err) ? arr_rdata : 32'd0;

endmodule
